// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 2-flop input synchronizer, valid/ready output and error pulses.
module uart_rx #(
  parameter int DATA_LEN = 8,
  parameter int CLK_DIV  = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_in,
  input  logic                rx_ready,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                rx_busy,
  output logic                frame_err,
  output logic                overrun_err
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = DATA_LEN > 1 ? $clog2(DATA_LEN) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_LEN - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic [CW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_LEN-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_err_q, overrun_err_d;
  logic                rx_s;
  assign rx_s        = sync_q[1];
  assign sync_d      = {sync_q[0], rx_in};
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_busy     = state_q != IDLE;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q + 1'b1;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q && !rx_ready;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d   = START;
        clk_cnt_d = '0;
      end
      // Re-checking the line at mid start bit rejects short glitches.
      START: if (clk_cnt_q == HALF) begin
        state_d   = rx_s ? IDLE : DATA;
        clk_cnt_d = '0;
      end
      DATA: if (clk_cnt_q == FULL) begin
        shift_d[bit_cnt_q] = rx_s;
        clk_cnt_d          = '0;
        state_d            = bit_cnt_q == LAST ? STOP : DATA;
        bit_cnt_d          = bit_cnt_q == LAST ? '0 : bit_cnt_q + 1'b1;
      end
      STOP: if (clk_cnt_q == FULL) begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        if (!rx_s) frame_err_d = 1'b1;
        else if (rx_valid_q && !rx_ready) overrun_err_d = 1'b1;
        else begin
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sync_q        <= 2'b11;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench driving serial frames into uart_rx and checking received words and error pulses.
module tb_uart_rx;
  localparam int DL = 8;
  localparam int CD = 16;
  localparam int LAT = 2 + CD / 2 + (DL + 1) * CD + 1;
  logic          clk = 1'b0, rst_n = 1'b0, rx_in = 1'b1, rx_ready = 1'b1;
  logic [DL-1:0] rx_data;
  logic          rx_valid, rx_busy, frame_err, overrun_err;
  int            n_chk = 0, n_err = 0, n_acc = 0, n_fe = 0, n_ov = 0;
  logic          fe_p = 1'b0, ov_p = 1'b0;
  logic [DL-1:0] exp_q[$];
  uart_rx #(.DATA_LEN(DL), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic line(input logic b);
    rx_in = b;
    repeat (CD) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [DL-1:0] d, input logic stop);
    line(1'b0);
    for (int i = 0; i < DL; i++) line(d[i]);
    line(stop);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (rx_valid && rx_ready) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("rx_data", rx_data, exp_q.pop_front());
      n_acc++;
    end
    if (frame_err) begin
      n_fe++;
      check("frame_err_single", fe_p, 0);
    end
    if (overrun_err) begin
      n_ov++;
      check("overrun_err_single", ov_p, 0);
    end
    fe_p = frame_err;
    ov_p = overrun_err;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int lat, a;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_oerr", overrun_err, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // basic frame plus start-edge to valid latency
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      while (!rx_valid && lat < 400) begin
        @(posedge clk);
        #1;
        lat++;
      end
    join
    check("latency_in_window", lat >= LAT - 1 && lat <= LAT + 1, 1);
    check("a5_count", n_acc, 1);
    check("a5_ferr", n_fe, 0);
    check("a5_oerr", n_ov, 0);
    check("a5_busy_after", rx_busy, 0);
    // short low glitch on the line
    rx_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_in = 1'b1;
    check("glitch_busy", rx_busy, 1);
    repeat (20) @(posedge clk);
    #1;
    check("glitch_idle", rx_busy, 0);
    check("glitch_count", n_acc, 1);
    check("glitch_ferr", n_fe, 0);
    check("glitch_oerr", n_ov, 0);
    // bad stop bit, then a good frame
    send_frame(8'h3C, 1'b0);
    line(1'b1);
    line(1'b1);
    check("ferr_count", n_fe, 1);
    check("ferr_valid", rx_valid, 0);
    check("ferr_acc", n_acc, 1);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    check("after_ferr_count", n_acc, 2);
    // overrun with consumer stalled
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_count", n_ov, 1);
    check("ovr_ferr", n_fe, 1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("ovr_cleared", rx_valid, 0);
    check("ovr_acc", n_acc, 3);
    rx_ready = 1'b1;
    // reset in the middle of bit 3 of 0xFF
    line(1'b0);
    for (int i = 0; i < 3; i++) line(1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_oerr", overrun_err, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6 * CD) @(posedge clk);
    #1;
    check("post_rst_acc", n_acc, 3);
    check("post_rst_busy", rx_busy, 0);
    check("post_rst_errs", n_fe + n_ov, 2);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    check("post_rst_81", n_acc, 4);
    // back-to-back stream of every byte value
    a = n_acc;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(DL'(i));
      send_frame(DL'(i), 1'b1);
    end
    lat = 0;
    while (rx_busy && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("stream_idle", rx_busy, 0);
    check("stream_count", n_acc - a, 256);
    check("stream_errs", n_fe + n_ov, 2);
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_LEN, default 8, number of data bits per frame.
REQ-002 Parameter CLK_DIV, default 100, clk cycles per bit; legal range >= 4.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_in  input  1  serial line, asynchronous to clk, idle high.
REQ-006 rx_ready  input  1  consumer accepts rx_data when rx_ready and rx_valid are both 1.
REQ-007 rx_data  output  DATA_LEN  last received word, bit 0 = first data bit on the line.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-009 rx_busy  output  1  high in every state except IDLE.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-011 overrun_err  output  1  one-cycle pulse: good frame completed while the previous word was unconsumed.

Function
REQ-012 Frame format SHALL be: start bit 0, then DATA_LEN data bits LSB first, then one stop bit 1, each CLK_DIV cycles long.
REQ-013 rx_in SHALL pass through a 2-flop synchronizer, reset to 1; rx_s denotes its output, and all logic SHALL use only rx_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; a single counter clk_cnt (width $clog2(CLK_DIV)) SHALL clear on every state change and otherwise increment.
REQ-015 IDLE -> START SHALL occur on the first cycle rx_s == 0.
REQ-016 START: when clk_cnt == CLK_DIV/2 - 1 (integer division), the FSM SHALL go to DATA if rx_s == 0, else return to IDLE with no output activity (glitch rejection).
REQ-017 DATA: when clk_cnt == CLK_DIV - 1, the FSM SHALL shift rx_s into the shift register at index bit_cnt, then reset clk_cnt to 0.
REQ-018 In DATA, after the sample with bit_cnt == DATA_LEN - 1 the FSM SHALL go to STOP and clear bit_cnt; otherwise it SHALL increment bit_cnt.
REQ-019 STOP: when clk_cnt == CLK_DIV - 1, the FSM SHALL sample rx_s and go to IDLE, so that sampling lands mid-stop-bit and the next start edge can be caught.
REQ-020 Stop sample 1 with rx_valid == 0, or with rx_valid == 1 and rx_ready == 1 in the same cycle: on the next cycle rx_data SHALL load the shift register and rx_valid SHALL be 1.
REQ-021 Stop sample 1 with rx_valid == 1 and rx_ready == 0: the new word SHALL be discarded, rx_data SHALL be unchanged, and overrun_err SHALL pulse for 1 cycle.
REQ-022 Stop sample 0: frame_err SHALL pulse for 1 cycle; rx_data and rx_valid SHALL be unchanged and the word discarded.
REQ-023 rx_valid SHALL clear on the cycle after rx_ready && rx_valid unless REQ-020 reloads it in that same cycle.
REQ-024 rx_data SHALL be stable while rx_valid == 1, except when reloaded by REQ-020.
REQ-025 Latency from rx_in's start-edge fall to rx_valid rise SHALL be 2 + CLK_DIV/2 + (DATA_LEN+1)*CLK_DIV + 1 cycles, ±1 for edge alignment.
REQ-026 rx_ready SHALL have no effect when rx_valid == 0.

Reset
REQ-027 While rst_n == 0: state = IDLE, clk_cnt = 0, bit_cnt = 0, shift register = 0, rx_data = 0, rx_valid = 0, rx_busy = 0, frame_err = 0, overrun_err = 0, synchronizer flops = 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no valid or error pulse.
REQ-029 After reset release the block SHALL wait in IDLE for rx_s == 0; a line held low through reset release SHALL be treated as a start edge.

Verification (CLK_DIV=16, DATA_LEN=8, rx_ready=1 unless stated)
REQ-030 Serial 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> one rx_valid pulse with rx_data = 0xA5, no error pulses, and rx_busy low after completion.
REQ-031 rx_in low for 4 cycles, then high -> FSM returns to IDLE at start-sample time, with no rx_valid, frame_err or overrun_err.
REQ-032 Frame 0x3C with stop bit 0 -> frame_err single pulse, rx_valid stays 0, and the next valid frame 0x55 is received correctly.
REQ-033 rx_ready = 0, frames 0x11 then 0x22 -> rx_valid = 1, rx_data = 0x11, overrun_err pulses at the end of 0x22; then rx_ready = 1 for 1 cycle -> rx_valid = 0.
REQ-034 rst_n pulsed low during bit 3 of 0xFF -> all outputs at reset values, no rx_valid; the following frame 0x81 is received correctly.
REQ-035 Loopback from the team's UART transmitter with matching parameters, 256 back-to-back words 0x00..0xFF -> every word received in order with zero errors.
